ula_seq_16_bits: RTL and testbench
==================================

ULA_SEQ_16_BITS -- requirements
Module: ula_seq_16_bits

Interface
REQ-001 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.
REQ-002 Ports, as name / direction / width / meaning, SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  block accepts request.
- req_a, req_b  in  16  operands.
- req_s  in  4  function select.
- req_m  in  1  mode, 0 arithmetic, 1 logic.
- req_c_in  in  1  carry into bit 0.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_f  out  16  result.
- resp_c_out  out  1  carry out of bit 15.
- resp_a_eq_b  out  1  both halves equal.
- ops_done  out  8  completed-operation count.
- alu_a, alu_b  out  8  operand bytes driven to the external ula_8_bits.
- alu_s  out  4  select to the ALU.
- alu_m  out  1  mode to the ALU.
- alu_c_in  out  1  carry to the ALU.
- alu_f  in  8  ALU result.
- alu_c_out  in  1  ALU carry out.
- alu_a_eq_b  in  1  ALU equality flag.

Function
REQ-003 The block SHALL run a 16-bit operation as two passes through one external 8-bit ALU: low byte first, then high byte.
REQ-004 The state machine SHALL have four states:
- IDLE: req_ready=1; go to LO when req_valid=1.
- LO: go to HI unconditionally.
- HI: go to RESP unconditionally.
- RESP: resp_valid=1; go to IDLE when resp_ready=1.
REQ-005 On acceptance (IDLE with req_valid=1), the block SHALL capture req_a, req_b, req_s, req_m and req_c_in into internal registers.
REQ-006 req_ready SHALL be 1 only in IDLE; requests offered in any other state SHALL be ignored.
REQ-007 In LO, the block SHALL drive alu_a=a[7:0], alu_b=b[7:0] and alu_c_in=captured c_in. At the LO->HI edge it SHALL register alu_f into f[7:0], and register alu_c_out and alu_a_eq_b.
REQ-008 In HI, the block SHALL drive alu_a=a[15:8], alu_b=b[15:8] and alu_c_in=the registered low carry. At the HI->RESP edge it SHALL register alu_f into f[15:8] and alu_c_out into resp_c_out.
REQ-009 resp_a_eq_b SHALL equal the AND of the registered low and high alu_a_eq_b values.
REQ-010 alu_s and alu_m SHALL equal the captured select and mode in every state.
REQ-011 In IDLE and RESP, alu_a, alu_b and alu_c_in SHALL drive the captured low-byte values.
REQ-012 The carry chain SHALL be used in both modes; in logic mode the ALU ignores alu_c_in.
REQ-013 Latency: for a request accepted at edge k, resp_valid SHALL be 1 after edge k+2. Minimum spacing between accepted requests SHALL be 4 cycles.
REQ-014 While resp_valid=1 and resp_ready=0, resp_f, resp_c_out and resp_a_eq_b SHALL hold stable.
REQ-015 When resp_valid and resp_ready are both 1 at an edge, ops_done SHALL increment modulo 256, wrapping 255->0.
REQ-016 resp_valid SHALL be 0 in every state other than RESP.

Reset
REQ-017 When rst_n=0, the state SHALL be IDLE and all captured registers SHALL be 0, giving: req_ready=1, resp_valid=0, resp_f=0, resp_c_out=0, resp_a_eq_b=0, ops_done=0, alu_a=0, alu_b=0, alu_s=0, alu_m=0, alu_c_in=0.
REQ-018 Reset asserted mid-operation (in LO, HI or RESP) SHALL abandon the operation. No response SHALL be produced and ops_done SHALL NOT increment.
REQ-019 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-020 The bench SHALL pair the block with ula_8_bits and cover these directed scenarios:
- Carry ripple: m=0, s=0001 (A+B+C_in), a=0x00FF, b=0x0001, c_in=0 -> resp_f=0x0100, resp_c_out=0.
- Wrap: m=0, s=0001, a=0xFFFF, b=0x0001, c_in=0 -> resp_f=0x0000, resp_c_out=1. Also c_in=1, a=0x7FFF, b=0x0000 -> resp_f=0x8000.
- Equality: a=b=0xAAAA -> resp_a_eq_b=1. Then a=0xAAAB, b=0xAAAA -> resp_a_eq_b=0. Then a=0xABAA, b=0xAAAA -> resp_a_eq_b=0.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid stays 1, outputs stable, req_ready=0, ops_done unchanged. ops_done increments by 1 at the handshake edge.
- Reset mid-op: rst_n pulsed low while in HI -> immediately req_ready=1, resp_valid=0, ops_done=0. No response follows.
- Counter wrap: 256 back-to-back operations -> ops_done returns to 0. All 32 (m,s) combinations SHALL be checked against a 16-bit reference model.

Source files
------------

// File: rtl/ula_seq_16_bits.sv
// 16-bit sequential ALU wrapper: runs one request as two byte passes through an external
// 8-bit ALU (low byte then high byte), carrying the low-byte carry into the high pass.
module ula_seq_16_bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_s,
    input  logic        req_m,
    input  logic        req_c_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_f,
    output logic        resp_c_out,
    output logic        resp_a_eq_b,
    output logic [7:0]  ops_done,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_c_in,
    input  logic [7:0]  alu_f,
    input  logic        alu_c_out,
    input  logic        alu_a_eq_b
);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  s_q, s_d;
    logic        m_q, m_d;
    logic        c_in_q, c_in_d;
    logic [7:0]  f_lo_q, f_lo_d;
    logic [7:0]  f_hi_q, f_hi_d;
    logic        c_lo_q, c_lo_d;
    logic        c_out_q, c_out_d;
    logic        eq_lo_q, eq_lo_d;
    logic        eq_hi_q, eq_hi_d;
    logic [7:0]  ops_q, ops_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        m_d          = m_q;
        c_in_d       = c_in_q;
        f_lo_d       = f_lo_q;
        f_hi_d       = f_hi_q;
        c_lo_d       = c_lo_q;
        c_out_d      = c_out_q;
        eq_lo_d      = eq_lo_q;
        eq_hi_d      = eq_hi_q;
        ops_d        = ops_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    s_d         = req_s;
                    m_d         = req_m;
                    c_in_d      = req_c_in;
                    req_ready_d = 1'b0;
                    state_d     = StLo;
                end
            end
            StLo: begin
                f_lo_d  = alu_f;
                c_lo_d  = alu_c_out;
                eq_lo_d = alu_a_eq_b;
                state_d = StHi;
            end
            StHi: begin
                f_hi_d       = alu_f;
                c_out_d      = alu_c_out;
                eq_hi_d      = alu_a_eq_b;
                resp_valid_d = 1'b1;
                state_d      = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    ops_d        = ops_q + 8'd1;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            s_q          <= 4'd0;
            m_q          <= 1'b0;
            c_in_q       <= 1'b0;
            f_lo_q       <= 8'd0;
            f_hi_q       <= 8'd0;
            c_lo_q       <= 1'b0;
            c_out_q      <= 1'b0;
            eq_lo_q      <= 1'b0;
            eq_hi_q      <= 1'b0;
            ops_q        <= 8'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            m_q          <= m_d;
            c_in_q       <= c_in_d;
            f_lo_q       <= f_lo_d;
            f_hi_q       <= f_hi_d;
            c_lo_q       <= c_lo_d;
            c_out_q      <= c_out_d;
            eq_lo_q      <= eq_lo_d;
            eq_hi_q      <= eq_hi_d;
            ops_q        <= ops_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Only the high pass swaps in the upper bytes and the chained low carry.
    always_comb begin
        alu_a    = a_q[7:0];
        alu_b    = b_q[7:0];
        alu_c_in = c_in_q;
        if (state_q == StHi) begin
            alu_a    = a_q[15:8];
            alu_b    = b_q[15:8];
            alu_c_in = c_lo_q;
        end
    end

    assign alu_s        = s_q;
    assign alu_m        = m_q;
    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_f       = {f_hi_q, f_lo_q};
    assign resp_c_out   = c_out_q;
    assign resp_a_eq_b  = eq_lo_q & eq_hi_q;
    assign ops_done     = ops_q;

endmodule

// File: tb/tb_ula_seq_16_bits.sv
// Bench for ula_seq_16_bits paired with a behavioural 8-bit ALU; results are compared with
// a 16-bit reference computed directly in wide arithmetic.
module tb_ula_seq_16_bits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_s;
    logic        req_m;
    logic        req_c_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_f;
    logic        resp_c_out;
    logic        resp_a_eq_b;
    logic [7:0]  ops_done;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_c_in;
    logic [7:0]  alu_f;
    logic        alu_c_out;
    logic        alu_a_eq_b;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_ops = 8'd0;

    ula_seq_16_bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_s      (req_s),
        .req_m      (req_m),
        .req_c_in   (req_c_in),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_f     (resp_f),
        .resp_c_out (resp_c_out),
        .resp_a_eq_b(resp_a_eq_b),
        .ops_done   (ops_done),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s      (alu_s),
        .alu_m      (alu_m),
        .alu_c_in   (alu_c_in),
        .alu_f      (alu_f),
        .alu_c_out  (alu_c_out),
        .alu_a_eq_b (alu_a_eq_b)
    );

    always #5 clk = ~clk;

    // Byte ALU: arithmetic ops are X + Y + c_in with bitwise-derived X/Y, logic ops use s as
    // the truth table of f = s[{a,b}]; equality compares the operand bytes.
    function automatic logic [9:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s, input logic m, input logic c);
        logic [8:0] x;
        logic [8:0] y;
        logic [8:0] sum;
        logic [7:0] f;
        if (m) begin
            for (int i = 0; i < 8; i++) f[i] = s[{a[i], b[i]}];
            return {a == b, 1'b0, f};
        end
        x = {1'b0, a};
        y = 9'd0;
        case (s)
            4'd0:  ;
            4'd1:  y = {1'b0, b};
            4'd2:  y = {1'b0, ~b};
            4'd3:  begin x = {1'b0, ~a}; y = {1'b0, b}; end
            4'd4:  y = {1'b0, a};
            4'd5:  x = {1'b0, a | b};
            4'd6:  x = {1'b0, a & b};
            4'd7:  y = {1'b0, a & b};
            4'd8:  y = {1'b0, a | b};
            4'd9:  x = {1'b0, a ^ b};
            4'd10: y = 9'h0FF;
            4'd11: x = {1'b0, ~a};
            4'd12: x = {1'b0, b};
            4'd13: x = {1'b0, a & ~b};
            4'd14: y = {1'b0, a & ~b};
            default: x = {1'b0, ~b};
        endcase
        sum = x + y + {8'd0, c};
        return {a == b, sum[8], sum[7:0]};
    endfunction

    always_comb begin
        {alu_a_eq_b, alu_c_out, alu_f} = alu8(alu_a, alu_b, alu_s, alu_m, alu_c_in);
    end

    // Whole-word reference: {a_eq_b, c_out, f}.
    function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m, input logic c);
        logic [15:0] na;
        logic [15:0] nb;
        logic [15:0] f;
        int unsigned av, bv, nav, nbv, cv, t;
        if (m) begin
            for (int i = 0; i < 16; i++) f[i] = s[{a[i], b[i]}];
            return {a == b, 1'b0, f};
        end
        na  = ~a;
        nb  = ~b;
        av  = 32'(a);
        bv  = 32'(b);
        nav = 32'(na);
        nbv = 32'(nb);
        cv  = 32'(c);
        case (s)
            4'd0:  t = av + cv;
            4'd1:  t = av + bv + cv;
            4'd2:  t = av + nbv + cv;
            4'd3:  t = nav + bv + cv;
            4'd4:  t = 2 * av + cv;
            4'd5:  t = (av | bv) + cv;
            4'd6:  t = (av & bv) + cv;
            4'd7:  t = av + (av & bv) + cv;
            4'd8:  t = av + (av | bv) + cv;
            4'd9:  t = (av ^ bv) + cv;
            4'd10: t = av + 32'hFFFF + cv;
            4'd11: t = nav + cv;
            4'd12: t = bv + cv;
            4'd13: t = (av & nbv) + cv;
            4'd14: t = av + (av & nbv) + cv;
            default: t = nbv + cv;
        endcase
        return {a == b, t[16], t[15:0]};
    endfunction

    task automatic check(input string tag, input string what, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s: observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_req;
        req_valid = 1'b1;
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_s     = 4'($urandom);
        req_m     = 1'($urandom);
        req_c_in  = 1'($urandom);
    endtask

    // One full transaction; junk requests are offered while busy and must be ignored.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic c, input int hold, input string tag);
        logic [17:0] r;
        logic [9:0]  lo;
        r  = ref16(a, b, s, m, c);
        lo = alu8(a[7:0], b[7:0], s, m, c);
        check(tag, "req_ready idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_s     = s;
        req_m     = m;
        req_c_in  = c;
        tick();
        junk_req();
        check(tag, "lo alu_a", 32'(alu_a), 32'(a[7:0]));
        check(tag, "lo alu_b", 32'(alu_b), 32'(b[7:0]));
        check(tag, "lo alu_c_in", 32'(alu_c_in), 32'(c));
        check(tag, "lo alu_s", 32'(alu_s), 32'(s));
        check(tag, "lo alu_m", 32'(alu_m), 32'(m));
        check(tag, "lo req_ready", 32'(req_ready), 32'd0);
        check(tag, "lo resp_valid", 32'(resp_valid), 32'd0);
        tick();
        junk_req();
        check(tag, "hi alu_a", 32'(alu_a), 32'(a[15:8]));
        check(tag, "hi alu_b", 32'(alu_b), 32'(b[15:8]));
        check(tag, "hi alu_c_in", 32'(alu_c_in), 32'(lo[8]));
        check(tag, "hi resp_valid", 32'(resp_valid), 32'd0);
        tick();
        check(tag, "resp_valid", 32'(resp_valid), 32'd1);
        check(tag, "resp_f", 32'(resp_f), 32'(r[15:0]));
        check(tag, "resp_c_out", 32'(resp_c_out), 32'(r[16]));
        check(tag, "resp_a_eq_b", 32'(resp_a_eq_b), 32'(r[17]));
        for (int i = 0; i < hold; i++) begin
            junk_req();
            tick();
            check(tag, "hold resp_valid", 32'(resp_valid), 32'd1);
            check(tag, "hold resp_f", 32'(resp_f), 32'(r[15:0]));
            check(tag, "hold resp_c_out", 32'(resp_c_out), 32'(r[16]));
            check(tag, "hold resp_a_eq_b", 32'(resp_a_eq_b), 32'(r[17]));
            check(tag, "hold req_ready", 32'(req_ready), 32'd0);
            check(tag, "hold ops_done", 32'(ops_done), 32'(exp_ops));
            check(tag, "hold alu_a", 32'(alu_a), 32'(a[7:0]));
        end
        resp_ready = 1'b1;
        tick();
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        exp_ops    = exp_ops + 8'd1;
        check(tag, "done ops_done", 32'(ops_done), 32'(exp_ops));
        check(tag, "done resp_valid", 32'(resp_valid), 32'd0);
        check(tag, "done req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] iv;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_a      = 16'd0;
        req_b      = 16'd0;
        req_s      = 4'd0;
        req_m      = 1'b0;
        req_c_in   = 1'b0;
        resp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #16;
        check("reset", "req_ready", 32'(req_ready), 32'd1);
        check("reset", "resp_valid", 32'(resp_valid), 32'd0);
        check("reset", "resp_f", 32'(resp_f), 32'd0);
        check("reset", "resp_c_out", 32'(resp_c_out), 32'd0);
        check("reset", "resp_a_eq_b", 32'(resp_a_eq_b), 32'd0);
        check("reset", "ops_done", 32'(ops_done), 32'd0);
        check("reset", "alu_a", 32'(alu_a), 32'd0);
        check("reset", "alu_b", 32'(alu_b), 32'd0);
        check("reset", "alu_s", 32'(alu_s), 32'd0);
        check("reset", "alu_m", 32'(alu_m), 32'd0);
        check("reset", "alu_c_in", 32'(alu_c_in), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        do_op(16'h00FF, 16'h0001, 4'b0001, 1'b0, 1'b0, 0, "ripple");
        check("ripple", "const f", 32'(resp_f), 32'h0100);
        check("ripple", "const c_out", 32'(resp_c_out), 32'd0);
        do_op(16'hFFFF, 16'h0001, 4'b0001, 1'b0, 1'b0, 0, "wrap");
        check("wrap", "const f", 32'(resp_f), 32'h0000);
        check("wrap", "const c_out", 32'(resp_c_out), 32'd1);
        do_op(16'h7FFF, 16'h0000, 4'b0001, 1'b0, 1'b1, 0, "cin");
        check("cin", "const f", 32'(resp_f), 32'h8000);
        do_op(16'hAAAA, 16'hAAAA, 4'b0001, 1'b0, 1'b0, 0, "eq_all");
        check("eq_all", "const eq", 32'(resp_a_eq_b), 32'd1);
        do_op(16'hAAAB, 16'hAAAA, 4'b0001, 1'b0, 1'b0, 0, "eq_lo_diff");
        check("eq_lo_diff", "const eq", 32'(resp_a_eq_b), 32'd0);
        do_op(16'hABAA, 16'hAAAA, 4'b0001, 1'b0, 1'b0, 0, "eq_hi_diff");
        check("eq_hi_diff", "const eq", 32'(resp_a_eq_b), 32'd0);
        do_op(16'h1234, 16'h5678, 4'b0010, 1'b0, 1'b1, 5, "backpressure");

        // Abort an operation while in the high pass.
        req_valid = 1'b1;
        req_a     = 16'hFFFF;
        req_b     = 16'hFFFF;
        req_s     = 4'b0001;
        req_m     = 1'b1;
        req_c_in  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        exp_ops = 8'd0;
        check("midreset", "req_ready", 32'(req_ready), 32'd1);
        check("midreset", "resp_valid", 32'(resp_valid), 32'd0);
        check("midreset", "ops_done", 32'(ops_done), 32'd0);
        check("midreset", "resp_f", 32'(resp_f), 32'd0);
        check("midreset", "alu_s", 32'(alu_s), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midreset", "no resp", 32'(resp_valid), 32'd0);
            check("midreset", "ops hold", 32'(ops_done), 32'd0);
        end

        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            do_op(16'($urandom), 16'($urandom), iv[3:0], iv[4], 1'($urandom), 0, "rand");
        end
        check("wrap256", "ops_done", 32'(ops_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
